// File: rtl/fortuna_reseed_ctrl.sv
// Fortuna reseed controller: owns generator key K and counter C, and on each
// reseed request hashes (K ^ seed) through the sha256d block, then installs the
// digest as the new K and increments C.
// Optional build macro FORTUNA_RESEED_TIMEOUT_EN adds a WAIT-state abort after
// TIMEOUT_CYCLES cycles with a sticky err_timeout flag; without it err_timeout
// is constant 0 and WAIT persists until the hash returns.
module fortuna_reseed_ctrl #(
    parameter int unsigned CTR_W          = 128,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               reseed_req,
    input  logic [255:0]       seed,
    output logic               reseed_ack,
    output logic               busy,
    output logic [255:0]       key,
    output logic               key_valid,
    output logic [CTR_W-1:0]   ctr,
    output logic               h_init,
    output logic [255:0]       h_data,
    input  logic               h_ready,
    input  logic [255:0]       h_hash,
    output logic               err_timeout
);

    localparam int unsigned DATA_W = 256;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Design-time sanity check on the timeout parameter
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("fortuna_reseed_ctrl: TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              wait_first;
    logic              wait_first_nxt;
    logic [DATA_W-1:0] key_nxt;
    logic [DATA_W-1:0] h_data_nxt;
    logic [CTR_W-1:0]  ctr_nxt;
    logic              key_valid_nxt;
    logic              reseed_ack_nxt;
    logic              h_init_nxt;
    logic              busy_nxt;
    logic              err_timeout_nxt;

`ifdef FORTUNA_RESEED_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            wait_first  <= 1'b0;
            key         <= '0;
            h_data      <= '0;
            ctr         <= '0;
            key_valid   <= 1'b0;
            reseed_ack  <= 1'b0;
            h_init      <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
`ifdef FORTUNA_RESEED_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            wait_first  <= wait_first_nxt;
            key         <= key_nxt;
            h_data      <= h_data_nxt;
            ctr         <= ctr_nxt;
            key_valid   <= key_valid_nxt;
            reseed_ack  <= reseed_ack_nxt;
            h_init      <= h_init_nxt;
            busy        <= busy_nxt;
            err_timeout <= err_timeout_nxt;
`ifdef FORTUNA_RESEED_TIMEOUT_EN
            wait_cnt    <= wait_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic; the commit values are loaded on the
    // edge entering COMMIT so key, ctr and reseed_ack move together.
    always_comb begin
        state_nxt       = state;
        wait_first_nxt  = 1'b0;
        key_nxt         = key;
        h_data_nxt      = h_data;
        ctr_nxt         = ctr;
        key_valid_nxt   = key_valid;
        reseed_ack_nxt  = 1'b0;
        h_init_nxt      = 1'b0;
        err_timeout_nxt = err_timeout;
`ifdef FORTUNA_RESEED_TIMEOUT_EN
        wait_cnt_nxt    = wait_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (reseed_req) begin
                    h_data_nxt = key ^ seed;
                    h_init_nxt = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_first_nxt = 1'b1;
`ifdef FORTUNA_RESEED_TIMEOUT_EN
                wait_cnt_nxt   = '0;
`endif
                state_nxt      = ST_WAIT;
            end
            ST_WAIT: begin
                // A strobe in the first WAIT cycle may be stale and is ignored
                if (!wait_first && h_ready) begin
                    key_nxt        = h_hash;
                    ctr_nxt        = ctr + CTR_W'(1);
                    key_valid_nxt  = 1'b1;
                    reseed_ack_nxt = 1'b1;
                    state_nxt      = ST_COMMIT;
                end
`ifdef FORTUNA_RESEED_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_nxt = 1'b1;
                    state_nxt       = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
`endif
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_fortuna_reseed_ctrl.sv
// Self-checking bench for fortuna_reseed_ctrl: directed scenarios plus random
// reseed transactions checked against a transaction-level model of K, C and
// key_valid. A narrow counter width is used so the counter wrap is exercised.
module tb_fortuna_reseed_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned TO = 16;

    logic             clk;
    logic             reset_n;
    logic             reseed_req;
    logic [255:0]     seed;
    logic             reseed_ack;
    logic             busy;
    logic [255:0]     key;
    logic             key_valid;
    logic [CW-1:0]    ctr;
    logic             h_init;
    logic [255:0]     h_data;
    logic             h_ready;
    logic [255:0]     h_hash;
    logic             err_timeout;

    fortuna_reseed_ctrl #(.CTR_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .reseed_req (reseed_req),
        .seed       (seed),
        .reseed_ack (reseed_ack),
        .busy       (busy),
        .key        (key),
        .key_valid  (key_valid),
        .ctr        (ctr),
        .h_init     (h_init),
        .h_data     (h_data),
        .h_ready    (h_ready),
        .h_hash     (h_hash),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: key, counter (plain integer mod 2^CW), valid, error
    logic [255:0] mk = '0;
    int           mc = 0;
    logic         mv = 1'b0;
    logic         me = 1'b0;

    // Pulse counters sampled on every clock edge
    int init_cnt = 0;
    int ack_cnt  = 0;
    always @(posedge clk) begin
        if (h_init)     init_cnt++;
        if (reseed_ack) ack_cnt++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_key"},   key, mk);
        check({tag, "_ctr"},   256'(ctr), 256'(mc));
        check({tag, "_valid"}, 256'(key_valid), 256'(mv));
    endtask

    // One reseed: hash returned in WAIT cycle dly (dly >= 1); optional stale
    // strobe in WAIT cycle 0; hold keeps the request asserted for a follow-on.
    task automatic run_txn(input logic [255:0] s, input logic [255:0] hsh,
                           input int dly, input bit stale, input bit hold);
        logic [255:0] exp_data;
        int ib;
        int ab;
        exp_data = mk ^ s;
        @(negedge clk);
        reseed_req = 1'b1;
        seed       = s;
        ib         = init_cnt;
        ab         = ack_cnt;
        @(posedge clk); #1;
        check("issue_busy",  256'(busy), 256'(1));
        check("issue_hinit", 256'(h_init), 256'(1));
        check("issue_hdata", h_data, exp_data);
        @(negedge clk);
        if (!hold) reseed_req = 1'b0;
        seed = rnd256();
        @(posedge clk); #1;
        check("wait_hinit", 256'(h_init), 256'(0));
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            h_ready = stale && (i == 0);
            h_hash  = rnd256();
            @(posedge clk); #1;
            check("wait_noack", 256'(reseed_ack), 256'(0));
            check("wait_hdata", h_data, exp_data);
            check("wait_key",   key, mk);
        end
        @(negedge clk);
        h_ready = 1'b1;
        h_hash  = hsh;
        @(posedge clk); #1;
        mk = hsh;
        mc = (mc + 1) % (1 << CW);
        mv = 1'b1;
        check("commit_ack",  256'(reseed_ack), 256'(1));
        check("commit_busy", 256'(busy), 256'(1));
        check_model("commit");
        check("init_pulses", 256'(init_cnt - ib), 256'(1));
        @(negedge clk);
        h_ready = 1'b0;
        if (!hold) begin
            @(posedge clk); #1;
            check("idle_ack",   256'(reseed_ack), 256'(0));
            check("idle_busy",  256'(busy), 256'(0));
            check("ack_pulses", 256'(ack_cnt - ab), 256'(1));
        end
    endtask

    initial begin
        int ab;
        reset_n    = 1'b0;
        reseed_req = 1'b0;
        seed       = '0;
        h_ready    = 1'b0;
        h_hash     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  256'(busy), 256'(0));
        check("rst_ack",   256'(reseed_ack), 256'(0));
        check("rst_hinit", 256'(h_init), 256'(0));
        check("rst_hdata", h_data, 256'(0));
        check("rst_err",   256'(err_timeout), 256'(0));
        check_model("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic reseed, then a second one chaining from the new key
        run_txn(256'h1, {32{8'hAB}}, 9, 1'b0, 1'b0);
        run_txn(256'hFF, rnd256(), 5, 1'b0, 1'b0);

        // Stale strobe in the first WAIT cycle must not be captured
        run_txn(rnd256(), rnd256(), 4, 1'b1, 1'b0);

        // Request held high: back-to-back transactions
        for (int i = 0; i < 4; i++)
            run_txn(rnd256(), rnd256(), $urandom_range(1, 6), 1'b0, (i < 3));

        // h_ready while idle is ignored
        ab = ack_cnt;
        @(negedge clk);
        h_ready = 1'b1;
        h_hash  = rnd256();
        repeat (3) @(posedge clk);
        #1;
        check("idle_rdy_busy", 256'(busy), 256'(0));
        check_model("idle_rdy");
        @(negedge clk);
        h_ready = 1'b0;
        @(posedge clk); #1;
        check("idle_rdy_acks", 256'(ack_cnt - ab), 256'(0));

        // Reset in WAIT, then a late strobe
        @(negedge clk);
        reseed_req = 1'b1;
        seed       = rnd256();
        @(posedge clk); #1;
        @(negedge clk);
        reseed_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        mk = '0;
        mc = 0;
        mv = 1'b0;
        check("midrst_busy", 256'(busy), 256'(0));
        check_model("midrst");
        ab = ack_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        h_ready = 1'b1;
        h_hash  = rnd256();
        repeat (3) @(posedge clk);
        #1;
        check("late_rdy_busy", 256'(busy), 256'(0));
        check_model("late_rdy");
        @(negedge clk);
        h_ready = 1'b0;
        @(posedge clk); #1;
        check("late_rdy_acks", 256'(ack_cnt - ab), 256'(0));
        run_txn(rnd256(), rnd256(), 3, 1'b0, 1'b0);

`ifdef FORTUNA_RESEED_TIMEOUT_EN
        // No hash ever returned: abort after TO WAIT cycles
        ab = ack_cnt;
        @(negedge clk);
        reseed_req = 1'b1;
        seed       = rnd256();
        @(posedge clk); #1;
        @(negedge clk);
        reseed_req = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i < int'(TO); i++) begin
            @(posedge clk); #1;
            check("to_wait_busy", 256'(busy), 256'(1));
        end
        @(posedge clk); #1;
        me = 1'b1;
        check("to_busy", 256'(busy), 256'(0));
        check("to_err",  256'(err_timeout), 256'(1));
        check("to_acks", 256'(ack_cnt - ab), 256'(0));
        check_model("to");
        run_txn(rnd256(), rnd256(), 2, 1'b0, 1'b0);
`endif

        // Random transactions; enough to wrap the narrow counter
        for (int n = 0; n < 20; n++) begin
            int  d;
            bit  st;
            st = 1'($urandom_range(0, 1));
            d  = $urandom_range(st ? 2 : 1, 10);
            run_txn(rnd256(), rnd256(), d, st, 1'($urandom_range(0, 1)) && (n != 19));
        end

        check("final_err", 256'(err_timeout), 256'(me));
        check_model("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fortuna_reseed_ctrl.md
Name: fortuna_reseed_ctrl

Overview:
- Initiator side of the sha256d request protocol (init / clear_input / ready / hash).
- Owns the Fortuna generator key K and counter C.
- On each reseed request it forms K XOR seed, issues one double-SHA256, installs the digest as the new K, and increments C.
- Sits between the entropy pool accumulator (upstream) and the sha256d block (downstream); K/C feed the block-cipher generator.

Parameters:
- CTR_W, 128, width of the generator counter C; wraps modulo 2^CTR_W.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT before an abort; used only when the optional feature is compiled in; must be >= 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- reseed_req  in  1  level request; sampled only in IDLE
- seed  in  256  seed material; captured in the cycle reseed_req is accepted
- reseed_ack  out  1  one-cycle pulse: new K/C installed
- busy  out  1  high in every state other than IDLE
- key  out  256  current generator key K
- key_valid  out  1  high once at least one reseed has committed
- ctr  out  CTR_W  current generator counter C
- h_init  out  1  request pulse to sha256d
- h_data  out  256  message to sha256d (clear_input)
- h_ready  in  1  sha256d completion strobe
- h_hash  in  256  sha256d digest; valid while h_ready is high
- err_timeout  out  1  sticky error flag; constant 0 when the optional feature is absent

Behaviour:
- Reset (async, reset_n low): all outputs, K, C and the seed/data registers are 0; state IDLE. Release is synchronous to clk.
- IDLE:
  - busy=0. If reseed_req=1: h_data <= key ^ seed (registered), state -> ISSUE.
  - Requests arriving while not in IDLE are ignored. The requester holds the level until reseed_ack.
- ISSUE: h_init=1 for exactly this one cycle; h_data stays stable from ISSUE until leaving WAIT; state -> WAIT.
- WAIT:
  - h_init=0. h_ready is ignored in the first WAIT cycle (guard against a stale strobe).
  - From the second WAIT cycle on, h_ready=1 -> capture h_hash into the staging register; state -> COMMIT.
- COMMIT (one cycle):
  - key <= staged hash; ctr <= ctr+1 (wraps to 0 at all-ones); key_valid <= 1; reseed_ack=1 this cycle; state -> IDLE.
  - key, ctr and reseed_ack all change on the same clock edge.
- Latency: request accepted at edge N, h_init high in cycle N+1. reseed_ack is high one cycle after the first qualifying h_ready cycle.
- Throughput: back-to-back requests are allowed. A request still asserted in the cycle after reseed_ack is accepted as a new reseed.
- Outputs key/ctr/key_valid are fully registered and change only in COMMIT. Consumers may sample them at any time.
- Counter wrap: 2^CTR_W-1 + 1 -> 0. key_valid stays 1 after wrap.
- Reset mid-operation: returns immediately to IDLE with K=0, C=0, key_valid=0. Any later h_ready is ignored until a new request passes the WAIT guard.
- h_ready in IDLE, ISSUE or COMMIT: ignored, with no state change.
- Seed changes after acceptance have no effect on the transaction in flight.

Optional Feature:
- Macro: FORTUNA_RESEED_TIMEOUT_EN.
- When defined:
  - A WAIT-cycle counter runs, cleared on ISSUE.
  - If it reaches TIMEOUT_CYCLES without a qualifying h_ready: state -> IDLE, err_timeout <= 1 (sticky until reset), K/C/key_valid unchanged, no reseed_ack.
  - Subsequent requests are still serviced.
- When undefined: no counter is present, err_timeout is tied to 0, and WAIT persists indefinitely.

Test Plan:
1. Reset, then a request with seed=256'h1, h_ready returned 10 cycles after h_init with h_hash=256'hAB..AB -> h_data=256'h1, single h_init pulse, key=256'hAB..AB, ctr=1, key_valid=1, one reseed_ack.
2. Second request with seed=256'hFF, key=X -> h_data=X^256'hFF; ctr=2.
3. h_ready forced high in the first WAIT cycle only -> no capture; capture happens on a later h_ready pulse; exactly one ack.
4. reseed_req held high continuously with h_ready pulsing -> consecutive transactions; ctr increments once per ack; no duplicate h_init within a transaction.
5. reset_n asserted in WAIT, then a late h_ready -> key=0, ctr=0, key_valid=0, no ack; the next request completes normally.
6. FORTUNA_RESEED_TIMEOUT_EN with TIMEOUT_CYCLES=16 and h_ready never asserted -> IDLE after 16 WAIT cycles, err_timeout=1, key/ctr unchanged; a following normal request still commits.
